// File: rtl/mult_pkg.sv
// Shared definitions for the arbitrated shift-add signed multiplier.
package mult_pkg;
  localparam int DATA_W = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
endpackage

// File: rtl/addsub9.sv
// 9-bit combinational adder/subtractor used for the partial-product step.
module addsub9
  import mult_pkg::*;
(
  input  logic signed [DATA_W:0] a,
  input  logic signed [DATA_W:0] b,
  input  logic                   sub,
  output logic signed [DATA_W:0] sum
);

  assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for an iterative 8x8 signed multiplier
// (one add/subtract and one arithmetic shift per multiplier bit).
module mult_arbiter
  import mult_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          req0_valid,
  input  logic [7:0]    req0_a,
  input  logic [7:0]    req0_b,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [7:0]    req1_a,
  input  logic [7:0]    req1_b,
  output logic          req1_ready,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [15:0]   rsp_product,
  output logic          busy
);

  state_t                   state, state_nxt;
  logic [2:0]               cnt;
  logic signed [DATA_W-1:0] acc;
  logic signed [DATA_W-1:0] mcand;
  logic [DATA_W-1:0]        mplier;
  logic                     x;
  logic                     last;
  logic                     id;
  logic                     grant0, grant1;
  logic signed [DATA_W:0]   sum;

  // last == 1 means requester 1 was granted most recently, so requester 0 wins ties.
  assign grant0 = req0_valid & (~req1_valid | last);
  assign grant1 = req1_valid & (~req0_valid | ~last);

  assign req0_ready  = Reset_n & (state == IDLE) & grant0;
  assign req1_ready  = Reset_n & (state == IDLE) & grant1;
  assign rsp_valid   = (state == DONE);
  assign rsp_id      = id;
  assign rsp_product = {acc, mplier};
  assign busy        = (state != IDLE);

  // The MSB of the multiplier carries negative weight, hence subtract on the last bit.
  addsub9 u_addsub (
    .a   ({acc[DATA_W-1], acc}),
    .b   ({mcand[DATA_W-1], mcand}),
    .sub (cnt == 3'd7),
    .sum (sum)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant0 | grant1) state_nxt = ADD;
      ADD:     state_nxt = SHIFT;
      SHIFT:   state_nxt = (cnt == 3'd7) ? DONE : ADD;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      x      <= 1'b0;
      id     <= 1'b0;
      last   <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            acc    <= '0;
            x      <= 1'b0;
            cnt    <= 3'd0;
            mcand  <= grant0 ? req0_a : req1_a;
            mplier <= grant0 ? req0_b : req1_b;
            id     <= grant1;
            last   <= grant1;
          end
        end
        ADD: begin
          if (mplier[0]) {x, acc} <= sum;
        end
        SHIFT: begin
          {x, acc, mplier} <= {x, x, acc, mplier[DATA_W-1:1]};
          cnt              <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: arbitration, latency, products, stall and reset.
module tb_mult_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [15:0] rsp_product;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;

  always #5 Clk = ~Clk;

  mult_arbiter dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .req0_valid  (req0_valid),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ready  (req1_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Called in the cycle after acceptance; returns the acceptance-relative cycle of rsp_valid.
  task automatic wait_rsp(output int cycles);
    cycles = 1;
    #1;
    while (!rsp_valid && cycles < 40) begin
      step();
      cycles++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    check("idle_after_hs", {busy, rsp_valid}, 0);
  endtask

  initial begin
    Reset_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    #2;
    check("rst_outputs", {rsp_valid, rsp_id, busy, req0_ready, req1_ready}, 0);
    check("rst_product", rsp_product, 16'h0000);
    step(); step();
    Reset_n = 1'b1;

    // 7 * -3, requester 0 alone
    req0_valid = 1; req0_a = 8'd7; req0_b = 8'hFD;
    #1;
    check("t1_ready", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 0; req0_a = 8'h11; req0_b = 8'h22;
    #1;
    check("t1_busy", {busy, req0_ready}, 2'b10);
    wait_rsp(lat);
    check("t1_latency", lat, 17);
    check("t1_product", rsp_product, 16'hFFEB);
    check("t1_id", rsp_id, 0);
    handshake();

    // Contention after reset: req0 first, then req1
    Reset_n = 0; #1; Reset_n = 1;
    step();
    req0_valid = 1; req0_a = 8'h80; req0_b = 8'h80;
    req1_valid = 1; req1_a = 8'd5;  req1_b = 8'd5;
    #1;
    check("t2_first_grant", {req0_ready, req1_ready}, 2'b10);
    step();
    #1;
    check("t2_no_ready_busy", {req0_ready, req1_ready}, 2'b00);
    wait_rsp(lat);
    check("t2_lat0", lat, 17);
    check("t2_product0", rsp_product, 16'h4000);
    check("t2_id0", rsp_id, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    #1;
    check("t2_second_grant", {req0_ready, req1_ready}, 2'b01);
    step();
    req0_valid = 0; req1_valid = 0;
    wait_rsp(lat);
    check("t2_lat1", lat, 17);
    check("t2_product1", rsp_product, 16'h0019);
    check("t2_id1", rsp_id, 1);
    handshake();

    // -128 * 127 with a stalled consumer
    req0_valid = 1; req0_a = 8'h80; req0_b = 8'h7F;
    #1;
    check("t3_ready", {req0_ready, req1_ready}, 2'b10);
    step();
    req1_valid = 1;
    wait_rsp(lat);
    check("t3_latency", lat, 17);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_stall_product", rsp_product, 16'hC080);
      check("t3_stall_valid", rsp_valid, 1);
      check("t3_stall_ready", {req0_ready, req1_ready}, 2'b00);
      step();
    end
    req0_valid = 0; req1_valid = 0;
    handshake();

    // Reset in the 8th busy cycle; req0 granted last, so only reset makes it win again
    req0_valid = 1; req0_a = 8'd3; req0_b = 8'd3;
    step();
    req1_valid = 1; req1_a = 8'd2; req1_b = 8'd2;
    for (int i = 0; i < 7; i++) step();
    check("t4_busy_pre", busy, 1);
    Reset_n = 0;
    #1;
    check("t4_rst_outputs", {rsp_valid, rsp_id, busy, req0_ready, req1_ready}, 0);
    check("t4_rst_product", rsp_product, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_no_valid", {rsp_valid, busy}, 0);
    end
    Reset_n = 1;
    #1;
    check("t4_grant_after_rst", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 0; req1_valid = 0;
    wait_rsp(lat);
    check("t4_latency", lat, 17);
    check("t4_product", rsp_product, 16'h0009);
    check("t4_id", rsp_id, 0);
    handshake();

    // Requester 1 stream: 0*0x55 then -1*-1
    req1_valid = 1; req1_a = 8'h00; req1_b = 8'h55;
    #1;
    check("t5_ready_a", {req0_ready, req1_ready}, 2'b01);
    step();
    req1_a = 8'hFF; req1_b = 8'hFF;
    #1;
    check("t5_busy_noready", req1_ready, 0);
    wait_rsp(lat);
    check("t5_product_a", rsp_product, 16'h0000);
    check("t5_id_a", rsp_id, 1);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    #1;
    check("t5_ready_b", {req0_ready, req1_ready}, 2'b01);
    step();
    req1_valid = 0;
    wait_rsp(lat);
    check("t5_latency_b", lat, 17);
    check("t5_product_b", rsp_product, 16'h0001);
    check("t5_id_b", rsp_id, 1);
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
